// File: rtl/hash_feeder.sv
// hash_feeder: splits a job message of up to MAX_BLK 64-byte blocks into
// per-block requests for an external hasher. Each block goes out with its
// chaining value, flags and zero-padded words. The result of the last block
// is returned as the digest. A per-block watchdog drops a stalled job.
//
// state | meaning
// IDLE  | ready for a job; Job_Rdy_O high
// ISSUE | one-cycle Strt_O for the current block
// WAIT  | holding block outputs until Vld_I or watchdog expiry
module hash_feeder #(
  parameter int MAX_BLK = 4,
  parameter int TIMEOUT = 127
) (
  input  logic                     Clk,
  input  logic                     Rst_I,
  input  logic                     Job_Vld_I,
  output logic                     Job_Rdy_O,
  input  logic [8:0]               Len_I,
  input  logic [MAX_BLK*16*32-1:0] Job_Msg_I,
  output logic                     Strt_O,
  output logic [31:0]              BL_O,
  output logic                     CS_flg_O,
  output logic                     CE_flg_O,
  output logic                     ROOT_flg_O,
  output logic [8*32-1:0]          H_O,
  output logic [16*32-1:0]         Msg_O,
  input  logic                     Vld_I,
  input  logic [8*32-1:0]          H_I,
  output logic                     Dig_Vld_O,
  output logic [8*32-1:0]          Digest_O,
  output logic                     Err_O
);

  localparam int CNT_W = $clog2(MAX_BLK + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  // IV0 sits in the least significant word of H_O.
  localparam logic [255:0] IV = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                                 32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                   state_q;
  state_t                   state_d;

  logic [MAX_BLK*512-1:0]   msg_q;
  logic [8:0]               len_q;
  logic [CNT_W-1:0]         nblk_q;
  logic [CNT_W-1:0]         blk_q;
  logic [255:0]             cv_q;
  logic [WD_W-1:0]          wdog_q;
  logic [255:0]             digest_q;
  logic                     dig_vld_q;
  logic                     err_len_q;

  logic                     accept;
  logic                     len_err;
  logic                     last_blk;
  logic                     timeout;
  logic [CNT_W-1:0]         nblk_calc;
  logic [511:0]             blk_sel;
  logic [9:0]               blk_base;

  assign accept  = Job_Vld_I && (state_q == IDLE);
  assign len_err = int'(Len_I) > 64 * MAX_BLK;

  // A zero-length job still needs one (empty) block for the root hash.
  assign nblk_calc = (Len_I == 9'd0) ? CNT_W'(1) : CNT_W'((int'(Len_I) + 63) / 64);

  assign last_blk = (blk_q == nblk_q - CNT_W'(1));

  // Expiry is decided in the cycle the count is reached, so a Vld_I arriving
  // in that same cycle can still take priority.
  assign timeout  = (state_q == WAIT) && (wdog_q == WD_W'(TIMEOUT - 1));

  assign blk_base = 10'(blk_q) << 6;

  // Select the current 64-byte block out of the captured message.
  always_comb begin
    blk_sel = '0;
    for (int i = 0; i < MAX_BLK; i++) begin
      if (blk_q == CNT_W'(i)) blk_sel = msg_q[i*512 +: 512];
    end
  end

  // State register.
  always_ff @(posedge Clk or posedge Rst_I) begin
    if (Rst_I) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !len_err) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (Vld_I)        state_d = last_blk ? IDLE : ISSUE;
        else if (timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job context, chaining value, watchdog and registered result pulses.
  always_ff @(posedge Clk or posedge Rst_I) begin
    if (Rst_I) begin
      msg_q     <= '0;
      len_q     <= '0;
      nblk_q    <= '0;
      blk_q     <= '0;
      cv_q      <= '0;
      wdog_q    <= '0;
      digest_q  <= '0;
      dig_vld_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      dig_vld_q <= 1'b0;
      err_len_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            msg_q     <= Job_Msg_I;
            len_q     <= Len_I;
            nblk_q    <= nblk_calc;
            blk_q     <= '0;
            cv_q      <= IV;
            err_len_q <= len_err;
          end
        end
        ISSUE: wdog_q <= '0;
        WAIT: begin
          if (Vld_I) begin
            if (last_blk) begin
              digest_q  <= H_I;
              dig_vld_q <= 1'b1;
            end else begin
              cv_q  <= H_I;
              blk_q <= blk_q + CNT_W'(1);
            end
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: block request fields are driven only while a block is in flight.
  always_comb begin
    Job_Rdy_O  = (state_q == IDLE);
    Strt_O     = (state_q == ISSUE);
    BL_O       = '0;
    CS_flg_O   = 1'b0;
    CE_flg_O   = 1'b0;
    ROOT_flg_O = 1'b0;
    H_O        = '0;
    Msg_O      = '0;
    Dig_Vld_O  = dig_vld_q;
    Digest_O   = digest_q;
    Err_O      = err_len_q || (timeout && !Vld_I);
    if (state_q == ISSUE || state_q == WAIT) begin
      H_O        = cv_q;
      BL_O       = last_blk ? (32'(len_q) - 32'(blk_base)) : 32'd64;
      CS_flg_O   = (blk_q == '0);
      CE_flg_O   = last_blk;
      ROOT_flg_O = last_blk;
      for (int w = 0; w < 16; w++) begin
        for (int b = 0; b < 4; b++) begin
          if ((blk_base + 10'(4*w + b)) < {1'b0, len_q})
            Msg_O[32*w + 8*b +: 8] = blk_sel[32*w + 8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_hash_feeder.sv
// Directed bench for hash_feeder with hand-computed expectations.
module tb_hash_feeder;

  localparam int MAX_BLK = 4;
  localparam int TIMEOUT = 127;
  localparam logic [255:0] IV = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                                 32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};

  logic                     Clk;
  logic                     Rst_I;
  logic                     Job_Vld_I;
  logic                     Job_Rdy_O;
  logic [8:0]               Len_I;
  logic [MAX_BLK*16*32-1:0] Job_Msg_I;
  logic                     Strt_O;
  logic [31:0]              BL_O;
  logic                     CS_flg_O;
  logic                     CE_flg_O;
  logic                     ROOT_flg_O;
  logic [255:0]             H_O;
  logic [511:0]             Msg_O;
  logic                     Vld_I;
  logic [255:0]             H_I;
  logic                     Dig_Vld_O;
  logic [255:0]             Digest_O;
  logic                     Err_O;

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] hx, hy, hz, hw, hv, d1, d2;
  int           early_err;

  hash_feeder #(.MAX_BLK(MAX_BLK), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst_I(Rst_I), .Job_Vld_I(Job_Vld_I), .Job_Rdy_O(Job_Rdy_O),
    .Len_I(Len_I), .Job_Msg_I(Job_Msg_I), .Strt_O(Strt_O), .BL_O(BL_O),
    .CS_flg_O(CS_flg_O), .CE_flg_O(CE_flg_O), .ROOT_flg_O(ROOT_flg_O),
    .H_O(H_O), .Msg_O(Msg_O), .Vld_I(Vld_I), .H_I(H_I),
    .Dig_Vld_O(Dig_Vld_O), .Digest_O(Digest_O), .Err_O(Err_O)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Strt_O, Dig_Vld_O and Err_O must be mutually exclusive at all times.
  always @(negedge Clk) begin
    if (!Rst_I) begin
      n_checks++;
      assert ((int'(Strt_O) + int'(Dig_Vld_O) + int'(Err_O)) <= 1)
        else begin
          n_errors++;
          $error("FAIL pulse_excl observed strt=%0b dig=%0b err=%0b expected at most one",
                 Strt_O, Dig_Vld_O, Err_O);
        end
    end
  end

  initial begin
    hx = {8{32'h0BAD_F00D}};
    hy = {8{32'h1234_5678}};
    hz = {8{32'hCAFE_BABE}};
    hw = {8{32'h0F0F_0F0F}};
    hv = {8{32'h7777_1111}};
    d1 = {8{32'hD1D1_D1D1}};
    d2 = {8{32'hD2D2_D2D2}};
    Rst_I = 1'b1; Job_Vld_I = 1'b0; Len_I = '0; Job_Msg_I = '0; Vld_I = 1'b0; H_I = '0;

    // Reset values
    #2;
    chk("rst_rdy", Job_Rdy_O, 1'b1);
    chk("rst_strt", Strt_O, 1'b0);
    chk("rst_err", Err_O, 1'b0);
    chk("rst_dig_vld", Dig_Vld_O, 1'b0);
    chk("rst_digest", Digest_O, 256'h0);
    chk("rst_h", H_O, 256'h0);
    chk("rst_msg", Msg_O, 512'h0);
    chk("rst_bl", BL_O, 32'h0);
    step(); step();
    Rst_I = 1'b0;
    step();

    // Vld_I in IDLE is ignored
    Vld_I = 1'b1; H_I = hz;
    step();
    Vld_I = 1'b0;
    chk("idle_vld_dig", Dig_Vld_O, 1'b0);
    chk("idle_vld_rdy", Job_Rdy_O, 1'b1);

    // Len=0: single empty block, all message bytes masked
    Job_Msg_I = '0;
    Job_Msg_I[0 +: 32]  = 32'hFFEEDDCC;
    Job_Msg_I[32 +: 32] = 32'h01020304;
    Len_I = 9'd0; Job_Vld_I = 1'b1;
    step();
    Job_Vld_I = 1'b0;
    chk("l0_strt", Strt_O, 1'b1);
    chk("l0_rdy", Job_Rdy_O, 1'b0);
    chk("l0_bl", BL_O, 32'd0);
    chk("l0_flags", {CS_flg_O, CE_flg_O, ROOT_flg_O}, 3'b111);
    chk("l0_h", H_O, IV);
    chk("l0_msg", Msg_O, 512'h0);
    step();
    chk("l0_strt_once", Strt_O, 1'b0);
    Vld_I = 1'b1; H_I = hx;
    step();
    Vld_I = 1'b0;
    chk("l0_dig_vld", Dig_Vld_O, 1'b1);
    chk("l0_digest", Digest_O, hx);
    chk("l0_rdy_after", Job_Rdy_O, 1'b1);
    step();
    chk("l0_dig_pulse", Dig_Vld_O, 1'b0);
    chk("l0_digest_hold", Digest_O, hx);

    // Len=65: two blocks, second block keeps only one byte
    Job_Msg_I = '0;
    Job_Msg_I[0 +: 32]      = 32'h11223344;
    Job_Msg_I[16*32 +: 32]  = 32'hDDCCBBAA;
    Job_Msg_I[17*32 +: 32]  = 32'h99887766;
    Len_I = 9'd65; Job_Vld_I = 1'b1;
    step();
    Job_Vld_I = 1'b0;
    chk("l65_b0_strt", Strt_O, 1'b1);
    chk("l65_b0_bl", BL_O, 32'd64);
    chk("l65_b0_flags", {CS_flg_O, CE_flg_O, ROOT_flg_O}, 3'b100);
    chk("l65_b0_w0", Msg_O[31:0], 32'h11223344);
    Vld_I = 1'b1; H_I = hz;   // during ISSUE: must be ignored
    step();
    Vld_I = 1'b0;
    chk("l65_issue_vld_strt", Strt_O, 1'b0);
    chk("l65_issue_vld_h", H_O, IV);
    step();
    chk("l65_wait_hold_bl", BL_O, 32'd64);
    Vld_I = 1'b1; H_I = hy;
    step();
    Vld_I = 1'b0;
    chk("l65_b1_strt", Strt_O, 1'b1);
    chk("l65_b1_bl", BL_O, 32'd1);
    chk("l65_b1_flags", {CS_flg_O, CE_flg_O, ROOT_flg_O}, 3'b011);
    chk("l65_b1_h", H_O, hy);
    chk("l65_b1_w0", Msg_O[31:0], 32'h000000AA);
    chk("l65_b1_w1", Msg_O[63:32], 32'h0);
    step();
    Vld_I = 1'b1; H_I = hz;
    step();
    Vld_I = 1'b0;
    chk("l65_dig_vld", Dig_Vld_O, 1'b1);
    chk("l65_digest", Digest_O, hz);

    // Len=300: too long, error pulse, no start
    Len_I = 9'd300; Job_Vld_I = 1'b1;
    step();
    Job_Vld_I = 1'b0;
    chk("l300_err", Err_O, 1'b1);
    chk("l300_strt", Strt_O, 1'b0);
    chk("l300_rdy", Job_Rdy_O, 1'b1);
    step();
    chk("l300_err_pulse", Err_O, 1'b0);
    chk("l300_strt2", Strt_O, 1'b0);
    chk("l300_digest_hold", Digest_O, hz);

    // Len=128, Vld_I withheld: Err_O 127 cycles after Strt_O
    Len_I = 9'd128; Job_Vld_I = 1'b1;
    step();
    Job_Vld_I = 1'b0;
    chk("to_strt", Strt_O, 1'b1);
    early_err = 0;
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      if (Err_O) early_err++;
    end
    chk("to_no_early_err", early_err, 0);
    step();
    chk("to_err", Err_O, 1'b1);
    chk("to_err_dig", Dig_Vld_O, 1'b0);
    step();
    chk("to_idle_rdy", Job_Rdy_O, 1'b1);
    chk("to_err_pulse", Err_O, 1'b0);
    chk("to_digest_hold", Digest_O, hz);

    // Len=128, Vld_I on cycle 127 wins over the watchdog
    Job_Vld_I = 1'b1;
    step();
    Job_Vld_I = 1'b0;
    for (int k = 1; k < TIMEOUT; k++) step();
    step();
    Vld_I = 1'b1; H_I = hw;
    #1;
    chk("race_no_err", Err_O, 1'b0);
    step();
    Vld_I = 1'b0;
    chk("race_b1_strt", Strt_O, 1'b1);
    chk("race_b1_bl", BL_O, 32'd64);
    chk("race_b1_flags", {CS_flg_O, CE_flg_O, ROOT_flg_O}, 3'b011);
    chk("race_b1_h", H_O, hw);
    step();
    Vld_I = 1'b1; H_I = hv;
    step();
    Vld_I = 1'b0;
    chk("race_dig_vld", Dig_Vld_O, 1'b1);
    chk("race_digest", Digest_O, hv);

    // Len=256 (maximum), reset during WAIT of block 1
    Len_I = 9'd256; Job_Vld_I = 1'b1;
    step();
    Job_Vld_I = 1'b0;
    chk("l256_strt", Strt_O, 1'b1);
    chk("l256_bl", BL_O, 32'd64);
    chk("l256_flags", {CS_flg_O, CE_flg_O, ROOT_flg_O}, 3'b100);
    step();
    Vld_I = 1'b1; H_I = hy;
    step();
    Vld_I = 1'b0;
    chk("l256_b1_flags", {CS_flg_O, CE_flg_O, ROOT_flg_O}, 3'b000);
    step();
    Rst_I = 1'b1;
    #1;
    chk("mid_rst_rdy", Job_Rdy_O, 1'b1);
    chk("mid_rst_strt", Strt_O, 1'b0);
    chk("mid_rst_h", H_O, 256'h0);
    chk("mid_rst_msg", Msg_O, 512'h0);
    chk("mid_rst_bl", BL_O, 32'h0);
    chk("mid_rst_flags", {CS_flg_O, CE_flg_O, ROOT_flg_O}, 3'b000);
    chk("mid_rst_digest", Digest_O, 256'h0);
    step();
    Rst_I = 1'b0;
    Vld_I = 1'b1; H_I = hx;
    step();
    Vld_I = 1'b0;
    chk("post_rst_dig", Dig_Vld_O, 1'b0);
    chk("post_rst_err", Err_O, 1'b0);
    step();
    chk("post_rst_strt", Strt_O, 1'b0);
    chk("post_rst_dig2", Dig_Vld_O, 1'b0);

    // Back-to-back single-block jobs, busy offer ignored
    Job_Msg_I = '0;
    Job_Msg_I[0 +: 32]  = 32'h44332211;
    Job_Msg_I[32 +: 32] = 32'h88776655;
    Job_Msg_I[64 +: 32] = 32'hCCBBAA99;
    Len_I = 9'd10; Job_Vld_I = 1'b1;
    step();
    chk("bb1_strt", Strt_O, 1'b1);
    chk("bb1_h", H_O, IV);
    chk("bb1_bl", BL_O, 32'd10);
    chk("bb1_w2", Msg_O[95:64], 32'h0000AA99);
    chk("bb1_w3", Msg_O[127:96], 32'h0);
    Job_Msg_I = '0;
    Job_Msg_I[0 +: 32]  = 32'hA1B2C3D4;
    Job_Msg_I[32 +: 32] = 32'h55667788;
    Len_I = 9'd5;
    step();
    chk("bb_busy_rdy", Job_Rdy_O, 1'b0);
    chk("bb_busy_nocap_w0", Msg_O[31:0], 32'h44332211);
    chk("bb_busy_nocap_bl", BL_O, 32'd10);
    Vld_I = 1'b1; H_I = d1;
    step();
    Vld_I = 1'b0;
    chk("bb1_dig_vld", Dig_Vld_O, 1'b1);
    chk("bb1_digest", Digest_O, d1);
    chk("bb1_rdy_at_dig", Job_Rdy_O, 1'b1);
    step();
    Job_Vld_I = 1'b0;
    chk("bb2_strt", Strt_O, 1'b1);
    chk("bb2_bl", BL_O, 32'd5);
    chk("bb2_h", H_O, IV);
    chk("bb2_w0", Msg_O[31:0], 32'hA1B2C3D4);
    chk("bb2_w1", Msg_O[63:32], 32'h00000088);
    step();
    Vld_I = 1'b1; H_I = d2;
    step();
    Vld_I = 1'b0;
    chk("bb2_dig_vld", Dig_Vld_O, 1'b1);
    chk("bb2_digest", Digest_O, d2);
    step();
    chk("bb2_idle", Job_Rdy_O, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hash_feeder.md
HASH_FEEDER -- requirements
Module: hash_feeder

Interface
REQ-001 Parameters SHALL be:
- MAX_BLK, 4, maximum 64-byte blocks per job.
- TIMEOUT, 127, cycles allowed per block from Strt_O to Vld_I.
REQ-002 Ports SHALL be:
- Clk  in  1  single clock, rising edge.
- Rst_I  in  1  asynchronous, active-high reset.
- Job_Vld_I  in  1  job offered.
- Job_Rdy_O  out  1  feeder can accept a job.
- Len_I  in  9  job message length in bytes.
- Job_Msg_I  in  MAX_BLK*16*32  message; block b occupies words 16b..16b+15; little-endian bytes within each word.
- Strt_O  out  1  one-cycle start to the hasher.
- BL_O  out  32  block length in bytes.
- CS_flg_O, CE_flg_O, ROOT_flg_O  out  1 each  chunk start, chunk end and root flags.
- H_O  out  8*32  chaining value input to the hasher.
- Msg_O  out  16*32  block words to the hasher.
- Vld_I  in  1  hasher result valid.
- H_I  in  8*32  hasher output.
- Dig_Vld_O  out  1  one-cycle digest valid.
- Digest_O  out  8*32  final root hash.
- Err_O  out  1  one-cycle error pulse.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE and WAIT; Job_Rdy_O SHALL equal (state==IDLE), combinational.
REQ-004 In IDLE, Job_Vld_I&&Job_Rdy_O SHALL capture Job_Msg_I and Len_I, and SHALL set blk=0, cv=IV0..IV7 and nblk=max(1,ceil(Len_I/64)).
REQ-005 Accept with Len_I>64*MAX_BLK SHALL pulse Err_O on the next cycle, issue no Strt_O, and remain in IDLE.
REQ-006 A valid accept at cycle T SHALL enter ISSUE; Strt_O SHALL be 1 at cycle T+1 for exactly one cycle, then the FSM SHALL enter WAIT.
REQ-007 During ISSUE and WAIT, the following SHALL hold constant until the block completes:
- H_O=cv; Msg_O=block blk.
- BL_O=64 for non-last blocks; Len-64*blk for the last block (blk==nblk-1).
- CS_flg_O=(blk==0); CE_flg_O=ROOT_flg_O=(blk==nblk-1).
REQ-008 Msg_O byte b of word w SHALL be zero when 64*blk+4*w+b >= Len (padding mask).
REQ-009 Vld_I in WAIT on a non-last block at cycle V SHALL set cv<=H_I, blk<=blk+1, and Strt_O SHALL be 1 at V+1.
REQ-010 Vld_I in WAIT on the last block at cycle V SHALL set Digest_O<=H_I, pulse Dig_Vld_O at V+1, and return to IDLE.
REQ-011 Vld_I in IDLE or ISSUE SHALL be ignored.
REQ-012 A watchdog SHALL clear on Strt_O and count WAIT cycles; reaching TIMEOUT without Vld_I SHALL pulse Err_O, drop the job (no Dig_Vld_O) and return to IDLE.
REQ-013 If Vld_I arrives in the same cycle the watchdog reaches TIMEOUT, Vld_I SHALL win and no Err_O SHALL be raised.
REQ-014 Job_Vld_I while busy SHALL be ignored, with no capture.
REQ-015 Digest_O SHALL hold its last value until the next successful digest.
REQ-016 Strt_O, Dig_Vld_O and Err_O SHALL never be asserted together.

Reset
REQ-017 Rst_I SHALL asynchronously force state=IDLE, Strt_O=0, Dig_Vld_O=0, Err_O=0, Digest_O=0, H_O=0, Msg_O=0, BL_O=0, all flags 0, blk=0 and watchdog=0.
REQ-018 Rst_I mid-job SHALL abandon the job with no Dig_Vld_O or Err_O.
REQ-019 Job_Rdy_O SHALL be 1 while Rst_I is asserted (state IDLE).

Verification
REQ-020 Len=0 -> one Strt_O with BL_O=0, CS=CE=ROOT=1, H_O=IV, Msg_O all zero; Vld_I with H_I=X -> Dig_Vld_O next cycle, Digest_O=X.
REQ-021 Len=65, Job_Msg_I word16=0xDDCCBBAA -> block0: BL_O=64, CS=1, CE=ROOT=0; Vld_I with H_I=Y -> block1 Strt_O the next cycle with BL_O=1, CS=0, CE=ROOT=1, H_O=Y, Msg_O word0=0x000000AA.
REQ-022 Len=300 -> Err_O pulse one cycle after accept, no Strt_O, Job_Rdy_O stays 1.
REQ-023 Len=128 with Vld_I withheld -> Err_O exactly TIMEOUT(127) cycles after Strt_O, FSM returns to IDLE; Vld_I on cycle 127 -> no Err_O and the next block is issued.
REQ-024 Rst_I pulsed during WAIT of a 4-block job -> outputs go to reset values immediately; a later Vld_I produces no Dig_Vld_O.
REQ-025 Two back-to-back 1-block jobs -> second job accepted the cycle after Dig_Vld_O; Job_Vld_I asserted while busy is ignored.
